fc_lcc_tb_cmd_sched: RTL and testbench

FC_LCC_TB_CMD_SCHED -- requirements
Module: fc_lcc_tb_cmd_sched

---
 rtl/fc_lcc_tb_cmd_sched.sv | 176 +++++++++++++++++
 tb/tb_fc_lcc_tb_cmd_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_lcc_tb_cmd_sched.sv
// Command scheduler for the FC/LCC test-bench service block.
// Arbitrates NUM_REQ requesters round-robin into a small command FIFO and
// issues queued commands one at a time as a single-cycle strobe. It idles
// GAP_CYC cycles after a normal command and RST_HOLD cycles after RST_CMD.
//
// Ports:
//   clk                  - clock
//   rst                  - synchronous active-high reset
//   req_valid[NUM_REQ]   - per-requester command valid
//   req_cmd[8*NUM_REQ]   - per-requester command, requester i at [8i+7:8i]
//   req_ready[NUM_REQ]   - per-requester accept (combinational, one-hot or zero)
//   tb_service_cmd_valid - single-cycle issue strobe
//   tb_service_cmd       - issued command, held between strobes
//   busy                 - FSM not idle or queue not empty
//   fifo_count           - queue occupancy
module fc_lcc_tb_cmd_sched #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYC    = 1,
    parameter int unsigned RST_HOLD   = 12,
    parameter logic [7:0]  RST_CMD    = 8'h10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [8*NUM_REQ-1:0]            req_cmd,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            tb_service_cmd_valid,
    output logic [7:0]                      tb_service_cmd,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RR_W  = $clog2(NUM_REQ);
    localparam int unsigned TMR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        HOLD
    } state_t;

    state_t             state, state_d;
    logic [TMR_W-1:0]   tmr, tmr_d;
    logic [RR_W-1:0]    rr_ptr;
    logic [RR_W-1:0]    win_idx;
    logic               win_any;
    logic [NUM_REQ-1:0] grant_c;
    logic [7:0]         push_cmd;
    logic               push;
    logic               pop_c;
    logic               full;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_d;

    // Per-requester command slices
    logic [7:0] cmd_arr [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd
        assign cmd_arr[g] = req_cmd[8*g +: 8];
    end

    assign full = (count == CNT_W'(FIFO_DEPTH));

    // Round-robin search starting at rr_ptr; no grant while full or in reset
    always_comb begin
        int unsigned idx;
        idx     = 0;
        grant_c = '0;
        win_idx = '0;
        win_any = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!win_any && req_valid[RR_W'(idx)]) begin
                win_any = 1'b1;
                win_idx = RR_W'(idx);
            end
        end
        if (!rst && !full && win_any) begin
            grant_c[win_idx] = 1'b1;
        end
    end

    assign req_ready  = grant_c;
    assign push       = |grant_c;
    assign push_cmd   = cmd_arr[win_idx];
    assign fifo_count = count;

    // Occupancy update; simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count;
        case ({push, pop_c})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // Issue FSM: pop in IDLE, strobe in ISSUE, then count down GAP/HOLD
    always_comb begin
        state_d = state;
        tmr_d   = tmr;
        pop_c   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop_c   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (tb_service_cmd == RST_CMD) begin
                    state_d = HOLD;
                    tmr_d   = TMR_W'(RST_HOLD);
                end else if (GAP_CYC == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    tmr_d   = TMR_W'(GAP_CYC);
                end
            end
            GAP, HOLD: begin
                tmr_d = tmr - TMR_W'(1);
                if (tmr <= TMR_W'(1)) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // Queue storage; empty is tracked by count so storage needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            tmr                  <= '0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            rr_ptr               <= '0;
            tb_service_cmd       <= '0;
            tb_service_cmd_valid <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            state <= state_d;
            tmr   <= tmr_d;
            count <= count_d;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= (win_idx == RR_W'(NUM_REQ - 1)) ? '0 : win_idx + RR_W'(1);
            end
            if (pop_c) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                tb_service_cmd <= mem[rd_ptr];
            end
            tb_service_cmd_valid <= (state_d == ISSUE);
            busy                 <= (state_d != IDLE) || (count_d != '0);
        end
    end

endmodule

// File: tb/tb_fc_lcc_tb_cmd_sched.sv
// Self-checking bench for fc_lcc_tb_cmd_sched. The reference model tracks
// accepted commands as a list with accept times and computes each strobe
// time as max(accept+2, previous strobe + previous spacing); occupancy, busy
// and the held command value are derived from those lists.
module tb_fc_lcc_tb_cmd_sched;

    localparam int NR = 2;
    localparam int FD = 4;
    localparam int GC = 1;
    localparam int RH = 12;
    localparam logic [7:0] RC = 8'h10;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [8*NR-1:0]   req_cmd;
    logic [NR-1:0]     req_ready;
    logic              tb_service_cmd_valid;
    logic [7:0]        tb_service_cmd;
    logic              busy;
    logic [$clog2(FD):0] fifo_count;

    fc_lcc_tb_cmd_sched #(
        .NUM_REQ    (NR),
        .FIFO_DEPTH (FD),
        .GAP_CYC    (GC),
        .RST_HOLD   (RH),
        .RST_CMD    (RC)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_cmd              (req_cmd),
        .req_ready            (req_ready),
        .tb_service_cmd_valid (tb_service_cmd_valid),
        .tb_service_cmd       (tb_service_cmd),
        .busy                 (busy),
        .fifo_count           (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    // Reference model state
    int         acc_t[$];
    logic [7:0] acc_c[$];
    int         str_t[$];
    int         str_sp[$];
    int         nxt_free = -100;
    int         p_m      = 0;

    // Observation helpers
    int   last_acc  = -1;
    logic last_busy = 1'b1;
    int   obs_str[$];
    int   grants[$];
    bit   rec_grants = 1'b0;
    int   max_cnt    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic int m_count(int tc);
        int n = 0;
        foreach (acc_t[i]) if (acc_t[i] < tc) n++;
        foreach (str_t[i]) if (str_t[i] <= tc) n--;
        return n;
    endfunction

    function automatic logic m_valid(int tc);
        foreach (str_t[i]) if (str_t[i] == tc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] m_cmd(int tc);
        logic [7:0] c = 8'h00;
        foreach (str_t[i]) if (str_t[i] <= tc) c = acc_c[i];
        return c;
    endfunction

    function automatic logic m_busy(int tc);
        if (m_count(tc) != 0) return 1'b1;
        foreach (str_t[i]) if (tc >= str_t[i] && tc <= str_t[i] + str_sp[i] - 2) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: inputs already driven; check, update model, advance
    task automatic step();
        logic [NR-1:0] rdy_e;
        logic [7:0]    c;
        int            cnt_e;
        int            s;
        int            sp;
        int            idx;
        bit            found;
        #1;
        cnt_e = m_count(t);
        rdy_e = '0;
        found = 1'b0;
        if (!rst && cnt_e < FD) begin
            for (int k = 0; k < NR; k++) begin
                idx = (p_m + k) % NR;
                if (!found && req_valid[idx]) begin
                    rdy_e[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        check("ready",      32'(req_ready),            32'(rdy_e));
        check("fifo_count", 32'(fifo_count),           32'(cnt_e));
        check("valid",      32'(tb_service_cmd_valid), 32'(m_valid(t)));
        check("cmd",        32'(tb_service_cmd),       32'(m_cmd(t)));
        check("busy",       32'(busy),                 32'(m_busy(t)));

        if (tb_service_cmd_valid === 1'b1) obs_str.push_back(t);
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        last_busy = busy;
        for (int k = 0; k < NR; k++) begin
            if (rec_grants && req_ready[k] === 1'b1 && req_valid[k]) grants.push_back(k);
        end

        last_acc = -1;
        for (int k = 0; k < NR; k++) begin
            if (rdy_e[k] && req_valid[k]) begin
                c  = req_cmd[8*k +: 8];
                s  = (t + 2 > nxt_free) ? t + 2 : nxt_free;
                sp = (c == RC) ? RH + 2 : GC + 2;
                acc_t.push_back(t);
                acc_c.push_back(c);
                str_t.push_back(s);
                str_sp.push_back(sp);
                nxt_free = s + sp;
                p_m      = (k + 1) % NR;
                last_acc = k;
            end
        end
        if (rst) begin
            acc_t.delete();
            acc_c.delete();
            str_t.delete();
            str_sp.delete();
            nxt_free = -100;
            p_m      = 0;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (last_busy === 1'b0) done = 1'b1;
        end
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic push_one(input int r, input logic [7:0] c);
        bit done = 1'b0;
        req_valid    = '0;
        req_valid[r] = 1'b1;
        req_cmd[8*r +: 8] = c;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            if (last_acc == r) done = 1'b1;
        end
        check("push_timeout", 32'(done), 32'd1);
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] v;
        int p0;
        int k;

        rst       = 1'b1;
        req_valid = '0;
        req_cmd   = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", 32'(req_ready),            32'd0);
        check("rst_count", 32'(fifo_count),           32'd0);
        check("rst_valid", 32'(tb_service_cmd_valid), 32'd0);
        check("rst_cmd",   32'(tb_service_cmd),       32'd0);
        check("rst_busy",  32'(busy),                 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        t   = 0;

        // Single command into an idle queue
        wait_idle();
        push_one(0, 8'h05);
        step();
        #1;
        check("r35_valid", 32'(tb_service_cmd_valid), 32'd1);
        check("r35_cmd",   32'(tb_service_cmd),       32'h05);
        step();
        step();
        #1;
        check("r35_busy",  32'(busy), 32'd0);
        step();

        // Two requesters held valid: alternating grants, 3-cycle strobe spacing
        wait_idle();
        p0 = p_m;
        grants.delete();
        obs_str.delete();
        rec_grants = 1'b1;
        req_valid  = 2'b11;
        req_cmd    = {8'hB0, 8'hA0};
        repeat (12) step();
        req_valid  = '0;
        rec_grants = 1'b0;
        wait_idle();
        check("r36_ngrant", 32'(grants.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < grants.size()) check("r36_grant", 32'(grants[i]), 32'((p0 + i) % NR));
        end
        for (int i = 0; i < 5; i++) begin
            if (i + 1 < obs_str.size()) check("r36_space", 32'(obs_str[i+1] - obs_str[i]), 32'd3);
        end

        // Reset command followed by a normal one: 14-cycle spacing
        wait_idle();
        obs_str.delete();
        push_one(0, 8'h10);
        push_one(0, 8'h07);
        wait_idle();
        check("r37_n", 32'(obs_str.size()), 32'd2);
        if (obs_str.size() == 2) check("r37_space", 32'(obs_str[1] - obs_str[0]), 32'd14);

        // Six back-to-back requests into a 4-deep queue
        wait_idle();
        obs_str.delete();
        max_cnt = 0;
        k = 0;
        req_valid = 2'b01;
        for (int i = 0; i < 60 && k < 6; i++) begin
            req_cmd[7:0] = 8'(8'h20 + k);
            step();
            if (last_acc == 0) k++;
        end
        check("r38_acc", 32'(k), 32'd6);
        req_cmd[7:0] = 8'h26;
        #1;
        check("r38_full_ready", 32'(req_ready), 32'd0);
        step();
        req_valid = '0;
        wait_idle();
        check("r38_max", 32'(max_cnt), 32'd4);
        check("r38_n",   32'(obs_str.size()), 32'd6);

        // Reset during HOLD with two commands still queued
        wait_idle();
        push_one(0, 8'h10);
        push_one(1, 8'h31);
        push_one(0, 8'h32);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs_str.delete();
        #1;
        check("r39_count", 32'(fifo_count),           32'd0);
        check("r39_busy",  32'(busy),                 32'd0);
        check("r39_valid", 32'(tb_service_cmd_valid), 32'd0);
        repeat (20) step();
        check("r39_nstr",  32'(obs_str.size()), 32'd0);

        // Push and pop in the same cycle at occupancy 2
        wait_idle();
        push_one(0, 8'hA1);
        push_one(0, 8'hA2);
        push_one(0, 8'hA3);
        step();
        push_one(0, 8'hA4);
        #1;
        check("r40_count", 32'(fifo_count), 32'd2);
        step();
        wait_idle();

        // Randomized traffic with occasional reset commands and resets
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < NR; r++) begin
                v[r] = ($urandom_range(0, 2) == 0);
                req_cmd[8*r +: 8] = ($urandom_range(0, 5) == 0) ? RC : 8'($urandom_range(0, 255));
            end
            req_valid = v;
            rst = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
